// File: rtl/pipe_chain.sv
// -----------------------------------------------------------------------------
// pipe_chain
//   A chain of DEPTH pipeline registers carrying a WIDTH-bit payload (typically
//   a {pc, instruction} pair) with per-stage freeze and flush control.
//
//   A freeze on stage i stalls stage i and every stage upstream of it. The
//   first stage downstream of the frozen region receives bubbles. A flush
//   kills the content of its stage and takes priority over a hold.
//   Invalid stages always carry all-zero data.
//
//   Handshake: in_ready is combinational and equals NOT hold[0]. A word is
//   captured at a rising edge only when in_valid=1 and in_ready=1 (and no
//   reset/flush of stage 0). If in_valid=1 while in_ready=0, the producer must
//   keep the word stable until it is accepted. There is no backpressure on the
//   output side; out_valid/out_data simply present the last stage.
//
// Parameters
//   WIDTH  payload width per stage (1..256)
//   DEPTH  number of pipeline registers (1..8)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     payload on in_data is valid
//   in_data      payload entering stage 0
//   in_ready     stage 0 accepts in_data this cycle
//   freeze_vec   bit i requests stage i to hold
//   flush_vec    bit i kills the content of stage i
//   out_valid    valid bit of stage DEPTH-1
//   out_data     payload of stage DEPTH-1
//   stage_valid  per-stage valid bits
//   stage_data   all stage payloads, stage i at [i*WIDTH +: WIDTH]
//
// Optional feature (macro PIPE_CHAIN_STATS_EN)
//   bubble_count  edges (non-reset) at which out_valid was 0, saturating
//   flush_count   valid stages killed by flush, saturating
// -----------------------------------------------------------------------------
module pipe_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       freeze_vec,
    input  logic [DEPTH-1:0]       flush_vec,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data
`ifdef PIPE_CHAIN_STATS_EN
    ,
    output logic [31:0]            bubble_count,
    output logic [31:0]            flush_count
`endif
);

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_nxt;
    logic [WIDTH-1:0] d_q   [DEPTH];
    logic [WIDTH-1:0] d_nxt [DEPTH];

    // hold[i] is the OR of all freeze bits at or downstream of stage i.
    always_comb begin
        logic acc;
        hold = '0;
        acc  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc     = acc | freeze_vec[i];
            hold[i] = acc;
        end
    end

    assign in_ready = ~hold[0];

    // Next-state per stage: flush > hold > load.
    always_comb begin
        v_nxt = v_q;
        d_nxt = d_q;

        if (flush_vec[0]) begin
            v_nxt[0] = 1'b0;
            d_nxt[0] = '0;
        end else if (!hold[0]) begin
            v_nxt[0] = in_valid;
            d_nxt[0] = in_valid ? in_data : '0;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (flush_vec[i]) begin
                v_nxt[i] = 1'b0;
                d_nxt[i] = '0;
            end else if (!hold[i]) begin
                // Upstream stage is held: it keeps its word, so send a bubble.
                if (hold[i-1]) begin
                    v_nxt[i] = 1'b0;
                    d_nxt[i] = '0;
                end else begin
                    v_nxt[i] = v_q[i-1];
                    d_nxt[i] = d_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_nxt;
            d_q <= d_nxt;
        end
    end

    assign out_valid   = v_q[DEPTH-1];
    assign out_data    = d_q[DEPTH-1];
    assign stage_valid = v_q;

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_data[i*WIDTH +: WIDTH] = d_q[i];
        end
    end

`ifdef PIPE_CHAIN_STATS_EN
    logic [3:0]  n_flushed;
    logic [32:0] flush_sum;

    // Number of valid stages killed by a flush at this edge.
    always_comb begin
        n_flushed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_flushed = n_flushed + {3'b000, (v_q[i] & flush_vec[i])};
        end
    end

    assign flush_sum = {1'b0, flush_count} + {29'd0, n_flushed};

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (!v_q[DEPTH-1] && (bubble_count != 32'hFFFF_FFFF)) begin
                bubble_count <= bubble_count + 32'd1;
            end
            flush_count <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_chain
//   Self-checking bench for pipe_chain (WIDTH=64, DEPTH=4). A reference model
//   of per-stage content (arrays) plus an in-order expected queue for the
//   stream checks. Directed scenarios first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_pipe_chain;

    localparam int W = 64;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [D-1:0]   freeze_vec;
    logic [D-1:0]   flush_vec;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data;
`ifdef PIPE_CHAIN_STATS_EN
    logic [31:0]    bubble_count;
    logic [31:0]    flush_count;
`endif

    pipe_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .freeze_vec  (freeze_vec),
        .flush_vec   (flush_vec),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .stage_valid (stage_valid),
        .stage_data  (stage_data)
`ifdef PIPE_CHAIN_STATS_EN
        ,
        .bubble_count(bubble_count),
        .flush_count (flush_count)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic         mv [D];
    logic [W-1:0] md [D];
    logic [W-1:0] exp_q [$];
    bit           sb_on = 1'b0;
    longint       m_bub = 0;
    longint       m_flush = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model, check outputs.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] id,
                        input logic [D-1:0] fz, input logic [D-1:0] fl);
        logic         nv [D];
        logic [W-1:0] nd [D];
        logic [D-1:0] ev;
        logic [D*W-1:0] ed;
        bit hold_i;
        bit hold_up;
        rst = r; in_valid = iv; in_data = id; freeze_vec = fz; flush_vec = fl;
        #1;
        check("in_ready", {255'd0, in_ready}, {255'd0, !(|fz)});

        // A stage holds when it or anything downstream of it is frozen.
        for (int i = 0; i < D; i++) begin
            hold_i  = |(fz >> i);
            hold_up = (i > 0) ? |(fz >> (i - 1)) : 1'b0;
            if (r || fl[i]) begin
                nv[i] = 1'b0; nd[i] = '0;
            end else if (hold_i) begin
                nv[i] = mv[i]; nd[i] = md[i];
            end else if (i == 0) begin
                nv[i] = iv; nd[i] = iv ? id : '0;
            end else if (hold_up) begin
                nv[i] = 1'b0; nd[i] = '0;
            end else begin
                nv[i] = mv[i-1]; nd[i] = md[i-1];
            end
        end

        if (r) begin
            m_bub = 0; m_flush = 0;
        end else begin
            if (!mv[D-1]) m_bub++;
            for (int i = 0; i < D; i++) if (mv[i] && fl[i]) m_flush++;
        end

        if (sb_on && !r && iv && !(|fz)) exp_q.push_back(id);

        @(posedge clk);
        #1;
        mv = nv;
        md = nd;
        for (int i = 0; i < D; i++) begin
            ev[i] = mv[i];
            ed[i*W +: W] = md[i];
        end
        check("stage_valid", {252'd0, stage_valid}, {252'd0, ev});
        check("stage_data",  stage_data, ed);
        check("out_valid",   {255'd0, out_valid}, {255'd0, mv[D-1]});
        check("out_data",    {192'd0, out_data}, {192'd0, md[D-1]});
`ifdef PIPE_CHAIN_STATS_EN
        check("bubble_count", {224'd0, bubble_count}, {224'd0, 32'(m_bub)});
        check("flush_count",  {224'd0, flush_count},  {224'd0, 32'(m_flush)});
`endif
        // A last stage that was not held has just loaded a fresh word.
        if (sb_on && out_valid && !fz[D-1]) begin
            if (exp_q.size() == 0) check("sb_extra", {255'd0, out_valid}, 256'd0);
            else check("sb_order", {192'd0, out_data}, {192'd0, exp_q.pop_front()});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic fill(input logic [W-1:0] base);
        for (int k = 0; k < D; k++) step(1'b0, 1'b1, base + W'(k), '0, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] word;
        logic [D-1:0] fz;
        logic [D-1:0] fl;
        logic         iv;
        logic         r;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; freeze_vec = '0; flush_vec = '0;
        for (int i = 0; i < D; i++) begin mv[i] = 1'b0; md[i] = '0; end
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, '0, '0, '0);
        step(1'b1, 1'b1, 64'hFFFF, 4'b1111, '0);
        check("rst_stage_data", stage_data, 256'd0);
        check("rst_out_valid", {255'd0, out_valid}, 256'd0);

`ifdef PIPE_CHAIN_STATS_EN
        idle(3);
        check("bubble_3", {224'd0, bubble_count}, 256'd3);
`endif

        // Streaming 1..5: out_valid rises on the 4th edge after data 1 is captured
        sb_on = 1'b1;
        step(1'b0, 1'b1, 64'd1, '0, '0);
        step(1'b0, 1'b1, 64'd2, '0, '0);
        step(1'b0, 1'b1, 64'd3, '0, '0);
        check("lat_not_yet", {255'd0, out_valid}, 256'd0);
        step(1'b0, 1'b1, 64'd4, '0, '0);
        check("lat_valid", {255'd0, out_valid}, 256'd1);
        check("lat_data", {192'd0, out_data}, 256'd1);
        step(1'b0, 1'b1, 64'd5, '0, '0);
        check("stream_2", {192'd0, out_data}, 256'd2);
        idle(D);
        check("drained", {255'd0, out_valid}, 256'd0);

        // Freeze stage 1 for two cycles on a full pipe; producer holds word 14
        fill(64'd10);
        step(1'b0, 1'b1, 64'd14, 4'b0010, '0);
        check("frz_in_ready", {255'd0, in_ready}, 256'd0);
        check("frz_bubble_v", {255'd0, stage_valid[2]}, 256'd0);
        check("frz_bubble_d", {192'd0, stage_data[2*W +: W]}, 256'd0);
        check("frz_hold01", {254'd0, stage_valid[1:0]}, 256'd3);
        step(1'b0, 1'b1, 64'd14, 4'b0010, '0);
        for (int k = 14; k < 20; k++) step(1'b0, 1'b1, W'(k), '0, '0);
        idle(D);
        check("frz_sb_empty", 256'(exp_q.size()), 256'd0);

        // Flush beats freeze on stages 0 and 1
        sb_on = 1'b0;
        fill(64'h100);
        step(1'b0, 1'b1, 64'h200, 4'b0001, 4'b0011);
        check("flush_v", {254'd0, stage_valid[1:0]}, 256'd0);
        check("flush_d", {128'd0, stage_data[2*W-1:0]}, 256'd0);

`ifdef PIPE_CHAIN_STATS_EN
        idle(D);
        step(1'b0, 1'b1, 64'h300, '0, '0);
        step(1'b0, 1'b0, 64'h0, '0, '0);
        step(1'b0, 1'b1, 64'h301, '0, '0);
        step(1'b0, 1'b0, 64'h0, '0, 4'b0101);
`endif

        // Mid-stream reset with everything frozen
        fill(64'h400);
        step(1'b1, 1'b1, 64'h500, 4'b1111, '0);
        check("mrst_v", {252'd0, stage_valid}, 256'd0);
        check("mrst_d", stage_data, 256'd0);
        idle(D);
        check("mrst_no_capture", {255'd0, out_valid}, 256'd0);

        // Random freeze-only traffic with in-order scoreboard
        exp_q.delete();
        sb_on = 1'b1;
        word = {$urandom, $urandom};
        for (int k = 0; k < 300; k++) begin
            iv = ($urandom_range(0, 3) != 0);
            fz = ($urandom_range(0, 3) == 0) ? D'($urandom_range(1, 15)) : '0;
            step(1'b0, iv, word, fz, '0);
            if (iv && !(|fz)) word = {$urandom, $urandom};
        end
        idle(D + 2);
        check("rand_sb_empty", 256'(exp_q.size()), 256'd0);

        // Random traffic with flush and occasional reset
        sb_on = 1'b0;
        for (int k = 0; k < 400; k++) begin
            iv = ($urandom_range(0, 2) != 0);
            fz = ($urandom_range(0, 2) == 0) ? D'($urandom_range(0, 15)) : '0;
            fl = ($urandom_range(0, 3) == 0) ? D'($urandom_range(0, 15)) : '0;
            r  = ($urandom_range(0, 49) == 0);
            step(r, iv, {$urandom, $urandom}, fz, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the payload width per stage (the {pc, instruction} pair), legal range 1..256.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of pipeline registers in the chain, legal range 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the payload on in_data is valid.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the payload entering stage 0.
REQ-007 The block SHALL have port in_ready, output, 1 bit: stage 0 accepts in_data this cycle.
REQ-008 The block SHALL have port freeze_vec, input, DEPTH bits: bit i requests that stage i hold.
REQ-009 The block SHALL have port flush_vec, input, DEPTH bits: bit i kills the content of stage i.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the valid bit of stage DEPTH-1.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the payload of stage DEPTH-1.
REQ-012 The block SHALL have port stage_valid, output, DEPTH bits: the per-stage valid bits, bit i = stage i.
REQ-013 The block SHALL have port stage_data, output, DEPTH*WIDTH bits: all stage payloads flattened; stage i occupies bits [i*WIDTH +: WIDTH].

Function
REQ-014 Each stage i SHALL hold a register pair {V[i], D[i]}; outputs are driven directly from these registers, with no combinational path from inputs to out_valid, out_data, stage_valid or stage_data.
REQ-015 Hold rule: hold[i] SHALL equal the OR of freeze_vec[j] for all j >= i, so a freeze stalls its own stage and every upstream stage.
REQ-016 in_ready SHALL equal NOT hold[0], combinationally.
REQ-017 Per-stage priority, evaluated every edge, SHALL be rst > flush_vec[i] > hold[i] > load.
- flush: V[i]=0, D[i]=0.
- hold: V[i] and D[i] unchanged.
- load at stage 0: V[0]=in_valid, D[0]= in_valid ? in_data : 0.
- load at stage i>0: if hold[i-1]=1, a bubble is inserted (V[i]=0, D[i]=0); otherwise V[i]=V[i-1] and D[i]=D[i-1].
REQ-018 An invalid stage SHALL always carry D=0, giving deterministic zero data for bubbles.
REQ-019 With no freeze and no flush, latency SHALL be exactly DEPTH cycles from in_data capture to out_data, one word per cycle, in order, with no loss or duplication.
REQ-020 A payload offered with in_valid=1 while in_ready=0 SHALL NOT be captured; the producer must hold it.
REQ-021 A flush of a held stage SHALL clear that stage; upstream stages SHALL still hold if their hold[] is 1.
REQ-022 When freeze_vec drops to 0, all stages SHALL resume on the next edge with no lost or duplicated payload.
REQ-023 With DEPTH=1, in_data SHALL go straight to out_data through one register, with in_ready = NOT freeze_vec[0].

Reset
REQ-024 While rst=1 at an edge, every V[i], every D[i] and all counters SHALL become 0, regardless of freeze_vec, flush_vec and in_valid.
REQ-025 After reset, out_valid=0, out_data=0, stage_valid=0 and stage_data=0; in_ready follows REQ-016.
REQ-026 A reset asserted mid-stream SHALL discard all in-flight payloads, with no partial drain.

Configuration
REQ-027 Macro PIPE_CHAIN_STATS_EN SHALL control the statistics feature.
- When defined: two extra output ports exist.
  - bubble_count, output, 32 bits: increments on every non-reset edge at which out_valid=0.
  - flush_count, output, 32 bits: increments by the number of stages with V[i]=1 and flush_vec[i]=1 at that edge.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: neither port nor its logic exists, and all other behaviour is identical.

Verification (WIDTH=64, DEPTH=4 unless stated)
REQ-028 Streaming: apply rst, then in_valid=1 with in_data 1,2,3,4,5 on consecutive cycles -> out_valid rises on the 4th edge after data 1 is captured, then out_data reads 1..5 in order.
REQ-029 Freeze: full pipe, freeze_vec=4'b0010 for 2 cycles -> in_ready=0, stages 0 and 1 hold, stage 2 gets bubbles (V=0, D=0), stages 2 and 3 drain; after release the stream continues with no gaps in payload order.
REQ-030 Flush vs. freeze: flush_vec=4'b0011 and freeze_vec=4'b0001 on the same cycle -> stage_valid[1:0]=0 and stage_data of stages 0 and 1 = 0 next cycle.
REQ-031 Mid-stream reset: full pipe, freeze_vec=4'b1111, rst=1 for one cycle -> stage_valid=0 and stage_data=0 next cycle; ignored in_valid words are not captured.
REQ-032 Statistics (macro defined): 3 idle output cycles -> bubble_count=3; flush_vec=4'b0101 with both stages valid -> flush_count=2; forcing the counter to 0xFFFFFFFF -> it holds there.
REQ-033 DEPTH=1 build: value 0xDEADBEEF is captured and appears on out_data one cycle later; freeze_vec=1 holds it and drives in_ready=0.
